// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: lock input, control and sequenced reset/enable outputs of the PLL bring-up block
interface pll_reset_sequencer_if #(
  parameter int NUM_CE = 3,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 8
) ();
  logic                    pll_locked;
  logic                    soft_reset;
  logic                    loss_clear;
  logic [NUM_CE*DIV_W-1:0] ce_div;
  logic                    reset_out;
  logic                    ready;
  logic [NUM_CE-1:0]       ce;
  logic [CNT_W-1:0]        loss_count;
  logic [1:0]              state;
  modport master (
    output pll_locked, soft_reset, loss_clear, ce_div,
    input  reset_out, ready, ce, loss_count, state
  );
  modport slave (
    input  pll_locked, soft_reset, loss_clear, ce_div,
    output reset_out, ready, ce, loss_count, state
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: lock sync/filter, held downstream reset and programmable clock-enable strobes
module pll_reset_sequencer #(
  parameter int NUM_CE      = 3,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int RESET_HOLD  = 32,
  parameter int CNT_W       = 8
) (
  input logic clock,
  input logic reset_n,
  pll_reset_sequencer_if.slave bus
);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int HW = $clog2(RESET_HOLD + 1);
  typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic [FW-1:0] filt_cnt, filt_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [CNT_W-1:0] loss_cnt;
  logic [NUM_CE-1:0] ce_v;
  logic lock_s, loss_inc, run;
  assign lock_s = sync[SYNC_STAGES-1];
  assign run = state == RUN;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync     <= '0;
      state    <= WAIT_LOCK;
      filt_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], bus.pll_locked};
      state    <= state_nxt;
      filt_cnt <= filt_nxt;
      hold_cnt <= hold_nxt;
    end
  end
  // Lock loss wins over soft_reset; only losses after the filter has passed are counted.
  always_comb begin
    state_nxt = state;
    filt_nxt  = filt_cnt;
    hold_nxt  = hold_cnt;
    loss_inc  = 1'b0;
    case (state)
      WAIT_LOCK: if (lock_s) begin
        state_nxt = STABLE;
        filt_nxt  = '0;
      end
      STABLE: if (!lock_s) state_nxt = WAIT_LOCK;
        else if (filt_cnt == FW'(LOCK_FILTER - 1)) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
        end else filt_nxt = filt_cnt + FW'(1);
      HOLD: if (!lock_s) begin
        state_nxt = WAIT_LOCK;
        loss_inc  = 1'b1;
      end else if (bus.soft_reset) hold_nxt = '0;
        else if (hold_cnt == HW'(RESET_HOLD - 1)) state_nxt = RUN;
        else hold_nxt = hold_cnt + HW'(1);
      default: if (!lock_s) begin
        state_nxt = WAIT_LOCK;
        loss_inc  = 1'b1;
      end else if (bus.soft_reset) begin
        state_nxt = HOLD;
        hold_nxt  = '0;
      end
    endcase
  end
  always_comb begin
    bus.reset_out  = !run;
    bus.ready      = run;
    bus.state      = state;
    bus.ce         = ce_v;
    bus.loss_count = loss_cnt;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) loss_cnt <= '0;
    else if (bus.loss_clear) loss_cnt <= CNT_W'(loss_inc);
    else if (loss_inc && !(&loss_cnt)) loss_cnt <= loss_cnt + CNT_W'(1);
  end
  for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
    logic [DIV_W-1:0] cnt, raw, d;
    logic hit;
    assign raw = bus.ce_div[i*DIV_W +: DIV_W];
    assign d = raw == '0 ? DIV_W'(1) : raw;
    // >= rather than == so a divisor lowered below the running count strobes at once
    assign hit = cnt >= d - DIV_W'(1);
    assign ce_v[i] = run && hit;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) cnt <= '0;
      else cnt <= (run && !hit) ? cnt + DIV_W'(1) : '0;
    end
  end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed vectors against hand-computed sequencing, strobe and counter values
module tb_pll_reset_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int n;
  logic [2:0] ce_or;
  pll_reset_sequencer_if bus ();
  pll_reset_sequencer dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!bus.ready && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask
  task automatic hold_len(input int again, output int cnt, output logic [2:0] seen);
    bus.soft_reset = 1'b1;
    tick();
    bus.soft_reset = 1'b0;
    cnt = 0;
    seen = '0;
    while (bus.reset_out && cnt < 200) begin
      seen |= bus.ce;
      cnt++;
      if (cnt == again) bus.soft_reset = 1'b1;
      tick();
      bus.soft_reset = 1'b0;
    end
  endtask
  initial begin
    bus.pll_locked = 1'b0;
    bus.soft_reset = 1'b0;
    bus.loss_clear = 1'b0;
    bus.ce_div = {16'd5, 16'd1, 16'd0};
    tick(2);
    check("rst_state", bus.state, 0);
    check("rst_reset_out", bus.reset_out, 1);
    check("rst_ready", bus.ready, 0);
    check("rst_ce", bus.ce, 0);
    check("rst_loss", bus.loss_count, 0);
    reset_n = 1'b1;
    bus.pll_locked = 1'b1;
    tick(2);
    check("edge2_wait", bus.state, 0);
    tick();
    check("edge3_stable", bus.state, 1);
    tick(15);
    check("edge18_stable", bus.state, 1);
    tick();
    check("edge19_hold", bus.state, 2);
    tick(31);
    check("edge50_rdy_rst", {bus.ready, bus.reset_out}, 2'b01);
    tick();
    check("edge51_run", bus.state, 3);
    check("edge51_rdy_rst", {bus.ready, bus.reset_out}, 2'b10);
    for (int c = 1; c <= 15; c++) begin
      check($sformatf("ce_cyc%0d", c), bus.ce, {(c % 5 == 0), 2'b11});
      tick();
    end
    tick(3);
    bus.ce_div[32 +: 16] = 16'd2;
    #1;
    check("ce_lowered", bus.ce, 3'b111);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("ce2_div2_%0d", k), bus.ce[2], (k % 2 == 0));
    end
    hold_len(0, n, ce_or);
    check("soft_hold_len", n, 32);
    check("soft_hold_ce", ce_or, 0);
    check("soft_ready", bus.ready, 1);
    check("soft_restart_c1", bus.ce, 3'b011);
    tick();
    check("soft_restart_c2", bus.ce, 3'b111);
    hold_len(20, n, ce_or);
    check("soft_ext_len", n, 52);
    check("soft_ext_ce", ce_or, 0);
    bus.pll_locked = 1'b0;
    tick(2);
    check("fall_pending", bus.state, 3);
    tick();
    check("fall_state", bus.state, 0);
    check("fall_reset_out", bus.reset_out, 1);
    check("fall_ce", bus.ce, 0);
    check("fall_loss", bus.loss_count, 1);
    tick(3);
    bus.pll_locked = 1'b1;
    tick(10);
    check("glitch_stable", bus.state, 1);
    bus.pll_locked = 1'b0;
    tick(3);
    check("glitch_wait", bus.state, 0);
    check("glitch_loss", bus.loss_count, 1);
    tick(2);
    bus.pll_locked = 1'b1;
    wait_ready(n);
    check("relock_latency", n, 51);
    for (int k = 0; k < 300; k++) begin
      bus.pll_locked = 1'b0;
      tick(5);
      bus.pll_locked = 1'b1;
      wait_ready(n);
    end
    check("loss_saturate", bus.loss_count, 255);
    bus.pll_locked = 1'b0;
    tick(2);
    bus.loss_clear = 1'b1;
    tick();
    bus.loss_clear = 1'b0;
    check("clear_with_loss", bus.loss_count, 1);
    check("clear_with_loss_st", bus.state, 0);
    bus.loss_clear = 1'b1;
    tick();
    bus.loss_clear = 1'b0;
    check("clear_alone", bus.loss_count, 0);
    tick(3);
    bus.pll_locked = 1'b1;
    wait_ready(n);
    check("ready_again", n, 51);
    bus.pll_locked = 1'b0;
    tick(2);
    bus.soft_reset = 1'b1;
    tick();
    bus.soft_reset = 1'b0;
    check("soft_vs_loss_st", bus.state, 0);
    check("soft_vs_loss_cnt", bus.loss_count, 1);
    tick(3);
    bus.pll_locked = 1'b1;
    wait_ready(n);
    check("ready_pre_arst", n, 51);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_state", bus.state, 0);
    check("arst_reset_out", bus.reset_out, 1);
    check("arst_ready", bus.ready, 0);
    check("arst_ce", bus.ce, 0);
    check("arst_loss", bus.loss_count, 0);
    tick();
    reset_n = 1'b1;
    wait_ready(n);
    check("arst_release_latency", n, 51);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Parametrised clock-domain bring-up block placed directly after the board PLL wrapper and clocked by the PLL output (e.g. the 48 MHz USB clock). It synchronises and debounces the PLL lock flag, sequences a held synchronous reset to downstream logic, and then releases `NUM_CE` independent clock-enable strobes with runtime-programmable divide ratios. It also counts lock-loss events and supports a software-requested reset without touching the PLL.

## Interface
- `NUM_CE`, 3: number of clock-enable channels (≥1)
- `DIV_W`, 16: width of each channel divisor
- `SYNC_STAGES`, 2: synchroniser depth for `pll_locked` (≥2)
- `LOCK_FILTER`, 16: consecutive synced-lock cycles required before reset hold (≥1)
- `RESET_HOLD`, 32: cycles `reset_out` stays asserted after the filter passes (≥1)
- `CNT_W`, 8: lock-loss counter width

- `clock` in 1: PLL output clock; the only clock
- `reset_n` in 1: asynchronous, active-low reset
- `pll_locked` in 1: PLL LOCK, asynchronous to `clock`
- `soft_reset` in 1: synchronous request to re-run the reset hold
- `loss_clear` in 1: synchronous clear of `loss_count`
- `ce_div` in `NUM_CE*DIV_W`: channel i divisor in bits `[i*DIV_W +: DIV_W]`
- `reset_out` out 1: synchronous active-high reset for downstream logic
- `ready` out 1: high only in RUN
- `ce` out `NUM_CE`: per-channel single-cycle enable strobes
- `loss_count` out `CNT_W`: saturating lock-loss counter
- `state` out 2: 0 WAIT_LOCK, 1 STABLE, 2 HOLD, 3 RUN

## Operation
- `pll_locked` passes through `SYNC_STAGES` flops; the last-stage output is `lock_s`. No other logic samples `pll_locked`.
- FSM, all transitions on `clock` rising edge:
  - WAIT_LOCK: `lock_s`=1 → STABLE, filter counter = 0.
  - STABLE: `lock_s`=0 → WAIT_LOCK; otherwise the counter increments; after `LOCK_FILTER` cycles in STABLE → HOLD, hold counter = 0.
  - HOLD: `lock_s`=0 → WAIT_LOCK and `loss_count` increments; `soft_reset` → hold counter restarts at 0; after `RESET_HOLD` cycles → RUN.
  - RUN: `lock_s`=0 → WAIT_LOCK and `loss_count` increments; else `soft_reset` → HOLD with counter 0 and no count increment.
- Lock loss has priority over `soft_reset` in every state.
- `reset_out` = (state ≠ RUN) and `ready` = (state = RUN). Both are registered with the state, with no extra cycle of latency.
- CE channel i: `DIV_W` counter held at 0 outside RUN. In RUN it counts 0..d−1 and wraps, where d = `ce_div[i]`, and d=0 is treated as d=1.
  - `ce[i]` is high in the RUN cycle where counter ≥ d−1; that same edge resets the counter to 0.
  - d=1 gives `ce[i]` high every RUN cycle.
  - The first strobe is in RUN cycle d (1-based).
  - Lowering d below the current count gives an immediate strobe and wrap.
  - `ce` is always 0 outside RUN.
- `loss_count` saturates at all-ones. When `loss_clear` and an increment coincide, the result is 1. `loss_clear` alone gives 0.

## Timing
- Reset (`reset_n`=0, asynchronous): state=WAIT_LOCK, `reset_out`=1, `ready`=0, `ce`=0, `loss_count`=0, sync flops=0, all counters=0. Release is synchronous to the design; the first edge after release evaluates normally.
- Lock-rise latency at defaults, with `pll_locked` rising before edge 1:
  - `lock_s`=1 after edge 2.
  - STABLE from edge 3.
  - HOLD from edge 19.
  - RUN, `ready`=1 and `reset_out`=0 from edge 51.
  - General form: `SYNC_STAGES`+1+`LOCK_FILTER`+`RESET_HOLD`.
- Lock-fall latency: `SYNC_STAGES`+1 edges to WAIT_LOCK. `reset_out` asserts on that edge, and `ce` is 0 from that edge onward.
- A glitch on `pll_locked` shorter than one clock period may be missed. A glitch that reaches `lock_s` always restarts the sequence.
- `soft_reset` in RUN: `reset_out` is high for exactly `RESET_HOLD` cycles, starting the edge after `soft_reset` is sampled.

## Test plan
- Async reset mid-RUN with `pll_locked`=1 → all outputs at reset values immediately. After release, `ready` rises 51 edges later (defaults).
- `pll_locked` high for 10 cycles, then low, then high → FSM returns to WAIT_LOCK from STABLE with `loss_count`=0. `ready` rises 51 edges after the second rise.
- In RUN, drop lock 300 times with `CNT_W`=8 → `loss_count`=255. Then assert `loss_clear` together with a new loss → `loss_count`=1.
- `ce_div`={0,1,5} → in RUN, ch0 and ch1 strobe every cycle and ch2 strobes in RUN cycles 5, 10, 15. Changing ch2 to 2 while its counter is at 3 → strobe on the next cycle, then every 2 cycles.
- `soft_reset` pulse in RUN → `reset_out` is high for 32 cycles, `ce` is 0 throughout and the counters restart. A second `soft_reset` at hold cycle 20 extends the hold to 52 cycles total.
- `soft_reset` and lock loss in the same cycle in RUN → state goes to WAIT_LOCK and `loss_count` increments by 1.
